i2s_frame_sequencer: RTL

Front-end controller for the I2S-to-PWM path. It oversamples the raw I2S pins (SCK/WS/SD) in the system clock domain, assembles left and right words and mixes them to mono. It hands one PWM duty value per stereo frame to the PWM generator over a valid/ready handshake. It also sequences mute, resync and underrun handling, so the PWM core only sees clean, frame-aligned duty updates.

---
 rtl/i2s_pwm_pkg.sv | 20 ++
 rtl/i2s_frame_sequencer_rx_deser.sv | 104 ++++++++++
 rtl/i2s_frame_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/i2s_pwm_pkg.sv
// Shared types and helpers for the I2S-to-PWM front end.
// Provides the sequencer state enum, the default sample type and midscale().
package i2s_pwm_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN
    } state_e;

    // Offset-binary zero for a duty of the given width.
    function automatic logic [31:0] midscale(int unsigned bits);
        return 32'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/i2s_frame_sequencer_rx_deser.sv
// I2S receiver: pin synchronizers, SCK rise detect and word deserializer.
// Ports: clk, rst_n, clr (drop partial word), i2s_sck/ws/sd (raw pins),
//        word_done (strobe), word_ch (0=L,1=R), word (left-justified).
module i2s_rx_deser
    import i2s_pwm_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = SAMPLE_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   i2s_sck,
    input  logic                   i2s_ws,
    input  logic                   i2s_sd,
    output logic                   word_done,
    output logic                   word_ch,
    output logic [SAMPLE_BITS-1:0] word
);

    localparam int unsigned CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] SB_C = CW'(SAMPLE_BITS);

    logic sck_s1_q, sck_s1_d;
    logic sck_s2_q, sck_s2_d;
    logic sck_s3_q, sck_s3_d;
    logic ws_s1_q, ws_s1_d;
    logic ws_s2_q, ws_s2_d;
    logic sd_s1_q, sd_s1_d;
    logic sd_s2_q, sd_s2_d;
    logic ws_prev_q, ws_prev_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;

    logic rise;
    logic ws_edge;
    logic room;
    logic [SAMPLE_BITS-1:0] shift_nx;
    logic [CW-1:0] cnt_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_s3_q  <= 1'b0;
            ws_s1_q   <= 1'b0;
            ws_s2_q   <= 1'b0;
            sd_s1_q   <= 1'b0;
            sd_s2_q   <= 1'b0;
            ws_prev_q <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            sck_s1_q  <= sck_s1_d;
            sck_s2_q  <= sck_s2_d;
            sck_s3_q  <= sck_s3_d;
            ws_s1_q   <= ws_s1_d;
            ws_s2_q   <= ws_s2_d;
            sd_s1_q   <= sd_s1_d;
            sd_s2_q   <= sd_s2_d;
            ws_prev_q <= ws_prev_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        sck_s1_d  = i2s_sck;
        sck_s2_d  = sck_s1_q;
        sck_s3_d  = sck_s2_q;
        ws_s1_d   = i2s_ws;
        ws_s2_d   = ws_s1_q;
        sd_s1_d   = i2s_sd;
        sd_s2_d   = sd_s1_q;
        ws_prev_d = ws_prev_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;

        rise    = sck_s2_q & ~sck_s3_q;
        ws_edge = ws_s2_q ^ ws_prev_q;
        room    = bit_cnt_q < SB_C;

        // Bits past SAMPLE_BITS are dropped: long words keep their top bits.
        shift_nx = room ? {shift_q[SAMPLE_BITS-2:0], sd_s2_q}
                        : shift_q;
        cnt_nx   = room ? bit_cnt_q + CW'(1) : bit_cnt_q;

        // The bit at a WS change is the LSB of the outgoing channel.
        word_done = rise & ws_edge;
        word_ch   = ws_prev_q;
        word      = shift_nx << (SB_C - cnt_nx);

        if (rise) begin
            ws_prev_d = ws_s2_q;
            shift_d   = shift_nx;
            bit_cnt_d = ws_edge ? '0 : cnt_nx;
        end

        if (clr) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end
    end

endmodule

// File: rtl/i2s_frame_sequencer.sv
// I2S front end: frame lock, L/R mono mix, duty handshake, mute/underrun.
// Ports: clk, rst_n, i2s_sck/ws/sd, duty/duty_valid/duty_ready,
//        mute, overflow (sticky), ovf_clear.
module i2s_frame_sequencer
    import i2s_pwm_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS    = 16,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i2s_sck,
    input  logic                i2s_ws,
    input  logic                i2s_sd,
    output logic [PWM_BITS-1:0] duty,
    output logic                duty_valid,
    input  logic                duty_ready,
    output logic                mute,
    output logic                overflow,
    input  logic                ovf_clear
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_C = TW'(TIMEOUT_CYCLES);
    localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(midscale(PWM_BITS));

    state_e state_q, state_d;
    logic [SAMPLE_BITS-1:0] l_q, l_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic duty_valid_q, duty_valid_d;
    logic mute_q, mute_d;
    logic overflow_q, overflow_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic word_done;
    logic word_ch;
    logic [SAMPLE_BITS-1:0] word;
    logic word_l;
    logic word_r;
    logic frame;
    logic lock;
    logic timeout;
    logic [TW-1:0] tcnt_nx;
    logic signed [SAMPLE_BITS:0] sum;
    logic signed [SAMPLE_BITS:0] mono;
    logic [PWM_BITS-1:0] mix;

    i2s_rx_deser #(
        .SAMPLE_BITS(SAMPLE_BITS)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (timeout),
        .i2s_sck  (i2s_sck),
        .i2s_ws   (i2s_ws),
        .i2s_sd   (i2s_sd),
        .word_done(word_done),
        .word_ch  (word_ch),
        .word     (word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            l_q          <= '0;
            duty_q       <= MID;
            duty_valid_q <= 1'b0;
            mute_q       <= 1'b1;
            overflow_q   <= 1'b0;
            tcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            l_q          <= l_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            mute_q       <= mute_d;
            overflow_q   <= overflow_d;
            tcnt_q       <= tcnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        l_d          = l_q;
        duty_d       = duty_q;
        duty_valid_d = duty_valid_q;
        mute_d       = mute_q;
        overflow_d   = overflow_q & ~ovf_clear;

        word_l = word_done & ~word_ch;
        word_r = word_done & word_ch;
        frame  = (state_q == ST_RUN) & word_r;
        lock   = (state_q == ST_SYNC) & word_l;

        if (word_l) begin
            l_d = word;
        end

        // Right word arrives live; left comes from the register.
        sum  = $signed({l_q[SAMPLE_BITS-1], l_q})
             + $signed({word[SAMPLE_BITS-1], word});
        mono = sum >>> 1;
        mix  = PWM_BITS'(mono >>> (SAMPLE_BITS - PWM_BITS)) ^ MID;

        unique case (state_q)
            ST_IDLE: if (word_done) state_d = ST_SYNC;
            ST_SYNC: if (word_l) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_IDLE || frame || lock) begin
            tcnt_nx = '0;
        end else if (tcnt_q == TO_C) begin
            tcnt_nx = TO_C;
        end else begin
            tcnt_nx = tcnt_q + TW'(1);
        end
        tcnt_d  = tcnt_nx;
        timeout = (state_q != ST_IDLE) && (tcnt_nx == TO_C);

        if (duty_valid_q && duty_ready) begin
            duty_valid_d = 1'b0;
        end

        // A new frame wins over acceptance in the same cycle.
        if (frame) begin
            duty_d       = mix;
            duty_valid_d = 1'b1;
            mute_d       = 1'b0;
            if (duty_valid_q && !duty_ready) begin
                overflow_d = 1'b1;
            end
        end

        if (timeout) begin
            state_d      = ST_IDLE;
            duty_d       = MID;
            duty_valid_d = 1'b0;
            mute_d       = 1'b1;
            tcnt_d       = '0;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = duty_valid_q;
    assign mute       = mute_q;
    assign overflow   = overflow_q;

endmodule
